// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed hex display scanner with anti-ghost blanking and leading-zero suppression
module seg_scan_driver #(
  parameter int DIV = 100000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        blank_lz,
  output logic [2:0]  which,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK);
  localparam logic [16*7-1:0] LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                     7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   f_data;
  logic [7:0]    f_dp;
  logic          f_lz;
  logic          tick, wrap;
  logic [2:0]    hi;
  logic [3:0]    nib;
  assign tick = cnt == LAST;
  assign wrap = tick && idx == 3'd7;
  assign which = idx;
  assign nib = f_data[idx*4 +: 4];
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      f_data <= '0;
      f_dp <= '0;
      f_lz <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= tick ? idx + 3'd1 : idx;
      frame_done <= wrap;
      if (wrap) begin
        f_data <= data;
        f_dp <= dp;
        f_lz <= blank_lz;
      end
    end
  end
  // highest nonzero nibble of the latched frame; digit 0 when all zero
  always_comb begin
    hi = 3'd0;
    for (int j = 0; j < 8; j++) hi = (f_data[j*4 +: 4] != 4'd0) ? 3'(j) : hi;
  end
  always_comb begin
    seg = (cnt < BL || (f_lz && idx > hi)) ? 8'hFF : {~f_dp[idx], LUT[nib*7 +: 7]};
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized check of seg_scan_driver against a time-based behavioural model
module tb_seg_scan_driver;
  localparam int DIV = 4;
  localparam int BLANK = 1;
  localparam int FR = 8 * DIV;
  logic clk = 1'b0, rst = 1'b1, blank_lz = 1'b0;
  logic [31:0] data = '0;
  logic [7:0] dp = '0;
  logic [2:0] which;
  logic [7:0] seg;
  logic frame_done;
  int n_checks = 0, n_fail = 0;
  bit check_en = 1'b0;
  int t = 0;
  logic [31:0] f_data = '0;
  logic [7:0] f_dp = '0;
  logic f_lz = 1'b0, m_fd = 1'b0;
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank_lz(blank_lz),
    .which(which), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(int tt, logic [31:0] d, logic [7:0] p, logic lz);
    int c = tt % DIV;
    int k = (tt / DIV) % 8;
    int h = 0;
    for (int j = 0; j < 8; j++) if (d[4*j +: 4] != 4'd0) h = j;
    if (c < BLANK) return 8'hFF;
    if (lz && k > h) return 8'hFF;
    return {~p[k], lut[d[4*k +: 4]]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  // model: time since reset determines position; frame captured at the end of each 8-slot frame
  always @(posedge clk) begin
    if (rst) begin
      t <= 0;
      m_fd <= 1'b0;
      f_data <= '0;
      f_dp <= '0;
      f_lz <= 1'b0;
    end else begin
      t <= t + 1;
      m_fd <= (t % FR == FR - 1);
      if (t % FR == FR - 1) begin
        f_data <= data;
        f_dp <= dp;
        f_lz <= blank_lz;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("which", 32'(which), (t / DIV) % 8);
      chk("seg", 32'(seg), 32'(exp_seg(t, f_data, f_dp, f_lz)));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < FR + 8; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int fd_at, fd_cnt;
    step(3);
    chk("rst_which", 32'(which), 32'd0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_fd", 32'(frame_done), 32'd0);
    check_en = 1'b1;
    data = 32'h8888_8888;
    rst = 1'b0;
    fd_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        fd_at = i + 1;
        break;
      end
    end
    chk("first_fd_cycle", 32'(fd_at), 32'd32);
    chk("eight_blank", 32'(seg), 32'hFF);
    step(1);
    chk("eight_lit", 32'(seg), 32'h80);
    data = 32'h0000_00A5;
    blank_lz = 1'b1;
    wait_fd();
    step(1);
    chk("a5_d0", 32'(seg), 32'h92);
    step(4);
    chk("a5_d1", 32'(seg), 32'h88);
    step(4);
    chk("a5_d2", 32'(seg), 32'hFF);
    data = 32'h0;
    wait_fd();
    step(1);
    chk("zero_lz_d0", 32'(seg), 32'hC0);
    step(4);
    chk("zero_lz_d1", 32'(seg), 32'hFF);
    blank_lz = 1'b0;
    wait_fd();
    step(5);
    chk("zero_nolz_d1", 32'(seg), 32'hC0);
    fd_cnt = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (i % 7 == 3) data = $urandom;
    end
    chk("fd_per_64", 32'(fd_cnt), 32'd2);
    data = 32'h1;
    dp = 8'h01;
    wait_fd();
    step(1);
    chk("dp_d0", 32'(seg), 32'h79);
    step(4);
    chk("dp_d1", 32'(seg), 32'hC0);
    for (int i = 0; i < FR + 4 && t % FR != 22; i++) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_which", 32'(which), 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data = $urandom >> $urandom_range(0, 31);
        dp = 8'($urandom);
        blank_lz = 1'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
